piso_tx: RTL
============

# piso_tx

Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock, with framing strobes. It is the sending end of the team's serial bit link; the receiving end is a serial-in/parallel-out chain of D flip-flops clocked on the same edge. Streaming is back-to-back with no idle gap between words when a new word is offered on time.

## Interface
- WIDTH, 8: data word width; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- din  input  WIDTH  parallel word; sampled only on an accepted handshake.
- load_valid  input  1  din is offered.
- load_ready  output  1  block can accept din this cycle; combinational from state and counter.
- sout  output  WIDTH=1  serial data bit, registered.
- sout_valid  output  1  sout carries a frame bit this cycle, registered.
- sof  output  1  high with the first bit of a frame, registered.
- eof  output  1  high with the last bit of a frame, registered.
- busy  output  1  a frame is in progress (state != IDLE), registered.

## Operation
- States: IDLE, SHIFT, PAR. PAR exists only with the macro defined.
- Accept = load_valid && load_ready at a posedge. On accept, din is loaded into the shift register, the bit counter is cleared, and the state goes to SHIFT.
- load_ready is high in IDLE. It is also high on the cycle the final frame bit is being driven, which is the last SHIFT bit, or the PAR cycle when the macro is on. It is low at all other times.
- SHIFT: each cycle drives one data bit in the MSB_FIRST order, then advances the shift register and counter. The counter is $clog2(WIDTH) bits wide and runs 0..WIDTH-1.
- After the last data bit:
  - With parity on, the next state is PAR.
  - Otherwise, the next state is SHIFT if a new word was accepted that cycle, else IDLE.
- PAR: drives one parity bit. The next state is SHIFT if a word was accepted that cycle, else IDLE.
- sof is high on counter 0 of SHIFT.
- eof is high on the final frame bit: the last data bit, or the parity bit when the macro is on.
- din changes while load_ready=0 are ignored, as is load_valid while load_ready=0.
- In IDLE: sout=0, sout_valid=0, sof=0, eof=0.

## Timing
- Reset values:
  - sout=0, sout_valid=0, sof=0, eof=0, busy=0.
  - State is IDLE, so load_ready=1 in the first cycle after reset.
- Latency: a word accepted at edge N drives its first bit (sof=1) after edge N, for the cycle N+1..N+2.
- Frame length is WIDTH cycles of sout_valid=1, or WIDTH+1 cycles with parity.
- Back-to-back: an accept on the eof cycle makes the next sof the immediately following cycle. Zero gap.
- Reset mid-frame: after the reset edge all outputs take their reset values. The partial frame is dropped and never resumed.
- Simultaneous rst and load_valid: rst wins and the word is not accepted.
- Reset while load_valid is held: the word is accepted on the first edge after rst deasserts.

## Configuration
- PISO_TX_PARITY_EN:
  - Defined: an even-parity bit (XOR of all WIDTH data bits) is appended after the last data bit. sout_valid=1 and eof=1 on that bit.
  - Undefined: no PAR state, frames are WIDTH bits long, and eof falls on the last data bit.

## Test plan
- Reset, then WIDTH=8, MSB_FIRST=1, din=8'hA5 accepted at edge 0 -> sout=1,0,1,0,0,1,0,1 over cycles 1-8, sof only in cycle 1, eof only in cycle 8, busy=0 and load_ready=1 in cycle 9.
- MSB_FIRST=0, din=8'h01 -> sout=1 in cycle 1, then 0 for seven cycles, with sout_valid=1 for exactly 8 cycles.
- 8'hA5 then 8'h3C with load_valid held high -> 16 contiguous sout_valid cycles, sof in cycles 1 and 9, eof in cycles 8 and 16, second word bits 0,0,1,1,1,1,0,0.
- Assert rst during data bit 4 of 8'hFF -> next cycle sout=0, sout_valid=0, busy=0, load_ready=1. A following 8'h80 is sent cleanly.
- Toggle din and load_valid during cycles 2-7 of a frame -> no accept and no change to the bits being sent.
- With PISO_TX_PARITY_EN, din=8'h07 -> 9 valid cycles, parity bit 1 in cycle 9, eof only in cycle 9. With din=8'h03, the parity bit is 0.

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter with valid/ready load and sof/eof framing.
// Optional even-parity trailer bit enabled by defining PISO_TX_PARITY_EN.
module piso_tx #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef PISO_TX_PARITY_EN
    , PAR
`endif
  } state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic sout_n, valid_n, sof_n, eof_n;
  logic last, accept;
`ifdef PISO_TX_PARITY_EN
  logic par;
  assign load_ready = state != SHIFT;
`else
  assign load_ready = state == IDLE || last;
`endif
  assign last = cnt == LAST;
  assign accept = load_valid && load_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      sout <= 1'b0;
      sout_valid <= 1'b0;
      sof <= 1'b0;
      eof <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      sout <= sout_n;
      sout_valid <= valid_n;
      sof <= sof_n;
      eof <= eof_n;
      busy <= state_n != IDLE;
    end
  end
`ifdef PISO_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) par <= 1'b0;
    else if (accept) par <= ^din;
  end
`endif
  // The register holds the word rotated so the next bit to send sits one below the end.
  always_comb begin
    state_n = IDLE;
    cnt_n = cnt;
    sr_n = sr;
    sout_n = 1'b0;
    valid_n = 1'b0;
    sof_n = 1'b0;
    eof_n = 1'b0;
    if (accept) begin
      state_n = SHIFT;
      cnt_n = '0;
      sr_n = din;
      sout_n = MSB_FIRST ? din[WIDTH-1] : din[0];
      valid_n = 1'b1;
      sof_n = 1'b1;
    end else if (state == SHIFT && !last) begin
      state_n = SHIFT;
      cnt_n = cnt + 1'b1;
      sr_n = MSB_FIRST ? {sr[WIDTH-2:0], sr[WIDTH-1]} : {sr[0], sr[WIDTH-1:1]};
      sout_n = MSB_FIRST ? sr[WIDTH-2] : sr[1];
      valid_n = 1'b1;
`ifndef PISO_TX_PARITY_EN
      eof_n = cnt_n == LAST;
`endif
    end
`ifdef PISO_TX_PARITY_EN
    else if (state == SHIFT) begin
      state_n = PAR;
      sout_n = par;
      valid_n = 1'b1;
      eof_n = 1'b1;
    end
`endif
  end
endmodule
